// File: rtl/hdmi_verify_pkg.sv
// rtl/hdmi_verify_pkg.sv - shared tags, FSM encoding and header constants for the HDMI frame verifier
package hdmi_verify_pkg;

    localparam logic [7:0] TAG_LAT = 8'h00;
    localparam logic [7:0] TAG_PIX = 8'h10;
    localparam logic [7:0] TAG_SEQ = 8'h11;

    localparam logic [11:0] HDR_H = 12'd0;
    localparam logic [11:0] HDR_V = 12'd0;
    localparam logic [11:0] LAT_H = 12'd1;
    localparam logic [11:0] LAT_V = 12'd0;

    localparam logic [7:0] SYNC_ARM  = 8'hFF;
    localparam logic [7:0] SYNC_LOCK = 8'h00;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/verify_report_fifo.sv
// rtl/verify_report_fifo.sv - first-word-fall-through report queue with full/empty flags
module verify_report_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign do_push = push && (!full || do_pop);

    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hdmi_frame_verifier.sv
// rtl/hdmi_frame_verifier.sv - compares received HDMI pixels with the generator and queues report records
module hdmi_frame_verifier
    import hdmi_verify_pkg::*;
#(
    parameter int H_ACTIVE   = 1920,
    parameter int V_ACTIVE   = 1080,
    parameter int CW         = 8,
    parameter int NCH        = 3,
    parameter int TW         = 24,
    parameter int LAT_OFFSET = 'h92,
    parameter int LAT_EVERY  = 256,
    parameter int MAX_ERR    = 16,
    parameter int RPT_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic [11:0]       pix_h,
    input  logic [11:0]       pix_v,
    input  logic [NCH*CW-1:0] pix_data,
    input  logic [TW-1:0]     pix_time,
    input  logic [NCH*CW-1:0] exp_data,
    output logic [11:0]       exp_h,
    output logic [11:0]       exp_v,
    output logic [3:0]        sel,
    output logic [11:0]       step_count,
    input  logic [TW-1:0]     time_count,
    input  logic [CW-1:0]     tol,
    output logic              rpt_valid,
    output logic [63:0]       rpt_data,
    input  logic              rpt_ready,
    output logic              locked,
    output logic [7:0]        frame_count,
    output logic [15:0]       error_count,
    output logic              overflow
);

    localparam int CH1 = (NCH > 1) ? 1 : 0;

    logic              s1_valid;
    logic [NCH*CW-1:0] got;
    logic [TW-1:0]     got_time;

    state_t      state;
    logic [7:0]  expected_frame;
    logic [7:0]  err_frame;
    logic [15:0] frame_err;

    logic [CW-1:0]  exp_ch [NCH];
    logic [CW-1:0]  got_ch [NCH];
    logic [7:0]     diff8  [NCH];
    logic [NCH-1:0] ch_bad;

    logic        is_active;
    logic        is_header;
    logic        is_lat;
    logic        in_lock;
    logic        lat_due;
    logic        mismatch;
    logic        rec_room;
    logic [7:0]  hdr_frame;
    logic [23:0] lat24;
    logic [23:0] pix_diffs;
    logic        push;
    logic [63:0] push_data;
    logic        pop;
    logic        full;
    logic        empty;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign exp_ch[i] = exp_data[(NCH-1-i)*CW +: CW];
        assign got_ch[i] = got[(NCH-1-i)*CW +: CW];
        assign diff8[i]  = 8'(16'(exp_ch[i]) - 16'(got_ch[i]));
        assign ch_bad[i] = (exp_ch[i] >= got_ch[i]) ? ((exp_ch[i] - got_ch[i]) > tol)
                                                    : ((got_ch[i] - exp_ch[i]) > tol);
    end

    always_comb begin
        pix_diffs = '0;
        for (int i = 0; i < 3; i++) begin
            if (i < NCH) begin
                pix_diffs[(2-i)*8 +: 8] = diff8[i];
            end
        end
    end

    // S2 works on the registered coordinates; the generator answers for those same coordinates.
    assign is_active = s1_valid && (exp_h < 12'(H_ACTIVE)) && (exp_v < 12'(V_ACTIVE));
    assign is_header = (exp_h == HDR_H) && (exp_v == HDR_V);
    assign is_lat    = (exp_h == LAT_H) && (exp_v == LAT_V);
    assign in_lock   = (state == ST_LOCKED);
    assign hdr_frame = 8'(got_ch[NCH-1]);
    assign lat_due   = ((32'(frame_count) & (LAT_EVERY - 1)) == 0);
    assign lat24     = 24'(time_count - got_time - TW'(LAT_OFFSET));
    assign mismatch  = |ch_bad;
    assign rec_room  = (frame_err < 16'(MAX_ERR));

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (is_active && in_lock) begin
            if (is_header) begin
                if (hdr_frame != expected_frame) begin
                    push      = 1'b1;
                    push_data = {TAG_SEQ, expected_frame, hdr_frame, 40'd0};
                end
            end else if (is_lat) begin
                if (lat_due) begin
                    push      = 1'b1;
                    push_data = {TAG_LAT, lat24, err_frame, 24'd0};
                end
            end else if (mismatch && rec_room) begin
                push      = 1'b1;
                push_data = {TAG_PIX, 4'd0, exp_h, 4'd0, exp_v, pix_diffs};
            end
        end
    end

    assign pop       = rpt_valid && rpt_ready;
    assign rpt_valid = !empty;
    assign locked    = in_lock;

    verify_report_fifo #(
        .DEPTH (RPT_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (rpt_data),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            exp_h          <= '0;
            exp_v          <= '0;
            got            <= '0;
            got_time       <= '0;
            state          <= ST_HUNT;
            expected_frame <= 8'd1;
            err_frame      <= '0;
            frame_err      <= '0;
            sel            <= '0;
            step_count     <= '0;
            frame_count    <= '0;
            error_count    <= '0;
            overflow       <= 1'b0;
        end else begin
            s1_valid <= pix_valid;
            if (pix_valid) begin
                exp_h    <= pix_h;
                exp_v    <= pix_v;
                got      <= pix_data;
                got_time <= pix_time;
            end

            if (push && full && !pop) begin
                overflow <= 1'b1;
            end

            if (is_active && is_header) begin
                sel         <= got_ch[0][CW-1 -: 4];
                step_count  <= 12'({got_ch[0], got_ch[CH1]});
                frame_count <= hdr_frame;
                frame_err   <= '0;
                case (state)
                    ST_HUNT: begin
                        if (hdr_frame == SYNC_ARM) begin
                            state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (hdr_frame == SYNC_LOCK) begin
                            state          <= ST_LOCKED;
                            expected_frame <= 8'd1;
                        end else begin
                            state <= ST_HUNT;
                        end
                    end
                    ST_LOCKED: begin
                        if (hdr_frame != expected_frame) begin
                            expected_frame <= hdr_frame + 8'd1;
                            error_count    <= sat_inc16(error_count);
                            err_frame      <= sat_inc8(err_frame);
                        end else begin
                            expected_frame <= expected_frame + 8'd1;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end else if (is_active && is_lat) begin
                if (in_lock && lat_due) begin
                    err_frame <= '0;
                end
            end else if (is_active && in_lock && mismatch) begin
                error_count <= sat_inc16(error_count);
                err_frame   <= sat_inc8(err_frame);
                if (rec_room) begin
                    frame_err <= frame_err + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_frame_verifier.sv
// tb/tb_hdmi_frame_verifier.sv - directed self-checking bench for hdmi_frame_verifier
module tb_hdmi_frame_verifier;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [11:0] pix_h;
    logic [11:0] pix_v;
    logic [23:0] pix_data;
    logic [23:0] pix_time;
    logic [23:0] exp_data;
    logic [11:0] exp_h;
    logic [11:0] exp_v;
    logic [3:0]  sel;
    logic [11:0] step_count;
    logic [23:0] time_count;
    logic [7:0]  tol;
    logic        rpt_valid;
    logic [63:0] rpt_data;
    logic        rpt_ready;
    logic        locked;
    logic [7:0]  frame_count;
    logic [15:0] error_count;
    logic        overflow;

    int          tests = 0;
    int          fails = 0;
    logic        collect = 1'b0;
    int          n_pop = 0;
    logic [63:0] first_rec = '0;
    logic [63:0] last_rec = '0;
    logic [63:0] want;

    always #5 clk = ~clk;

    hdmi_frame_verifier dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_h       (pix_h),
        .pix_v       (pix_v),
        .pix_data    (pix_data),
        .pix_time    (pix_time),
        .exp_data    (exp_data),
        .exp_h       (exp_h),
        .exp_v       (exp_v),
        .sel         (sel),
        .step_count  (step_count),
        .time_count  (time_count),
        .tol         (tol),
        .rpt_valid   (rpt_valid),
        .rpt_data    (rpt_data),
        .rpt_ready   (rpt_ready),
        .locked      (locked),
        .frame_count (frame_count),
        .error_count (error_count),
        .overflow    (overflow)
    );

    // Reference pattern: all channels 0x80 at (10,20), drifting with h and v elsewhere.
    function automatic logic [23:0] gen(input logic [11:0] h, input logic [11:0] v);
        logic [7:0] hb;
        logic [7:0] vb;
        hb = h[7:0];
        vb = v[7:0];
        return {8'h80 + vb - 8'd20, 8'h80 + hb - 8'd10, 8'h80};
    endfunction

    assign exp_data = gen(exp_h, exp_v);

    always @(negedge clk) begin
        if (collect && rpt_valid && rpt_ready) begin
            if (n_pop == 0) begin
                first_rec <= rpt_data;
            end
            last_rec <= rpt_data;
            n_pop    <= n_pop + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_pix(input logic [11:0] h, input logic [11:0] v,
                            input logic [23:0] d, input logic [23:0] t);
        pix_h     = h;
        pix_v     = v;
        pix_data  = d;
        pix_time  = t;
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic header(input logic [7:0] f);
        send_pix(12'd0, 12'd0, {8'hA5, 8'h3C, f}, 24'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one();
        rpt_ready = 1'b1;
        @(negedge clk);
        rpt_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        pix_valid  = 1'b0;
        pix_h      = '0;
        pix_v      = '0;
        pix_data   = '0;
        pix_time   = '0;
        time_count = 24'h300;
        tol        = 8'd2;
        rpt_ready  = 1'b0;
        idle(3);
        check("rst_locked", locked, 0);
        check("rst_rpt_valid", rpt_valid, 0);
        check("rst_error_count", error_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_sel", sel, 0);
        check("rst_step", step_count, 0);
        check("rst_exp_h", exp_h, 0);
        rst = 1'b0;
        idle(1);

        header(8'h00);
        idle(1);
        check("hunt_00_no_lock", locked, 0);
        header(8'hFF);
        idle(1);
        check("armed_not_locked", locked, 0);
        check("hdr_frame_ff", frame_count, 8'hFF);
        check("hdr_sel", sel, 4'hA);
        check("hdr_step", step_count, 12'h53C);
        header(8'h00);
        idle(1);
        check("locked_after_00", locked, 1);

        send_pix(12'd1, 12'd0, gen(12'd1, 12'd0), 24'h100);
        idle(1);
        check("lat_valid", rpt_valid, 1);
        check("lat_record", rpt_data, 64'h0000016E00000000);
        pop_one();
        check("lat_popped", rpt_valid, 0);

        send_pix(12'd2, 12'd0, gen(12'd2, 12'd0), 24'd0);
        send_pix(12'd5, 12'd3, gen(12'd5, 12'd3), 24'd0);
        header(8'h01);
        send_pix(12'd3, 12'd4, gen(12'd3, 12'd4), 24'd0);
        header(8'h02);
        send_pix(12'd7, 12'd9, gen(12'd7, 12'd9), 24'd0);
        idle(2);
        check("clean_no_records", rpt_valid, 0);
        check("clean_error_count", error_count, 0);
        check("clean_frame_02", frame_count, 8'h02);

        header(8'h05);
        idle(1);
        check("seq_valid", rpt_valid, 1);
        check("seq_record", rpt_data, 64'h1103050000000000);
        check("seq_error_count", error_count, 1);
        pop_one();
        header(8'h06);
        idle(1);
        check("seq_resync_no_record", rpt_valid, 0);
        check("seq_resync_count", error_count, 1);

        send_pix(12'd10, 12'd20, 24'h7E8380, 24'd0);
        idle(1);
        check("pix_record", rpt_data, 64'h10000A001402FD00);
        check("pix_error_count", error_count, 2);
        pop_one();
        send_pix(12'd11, 12'd20, 24'h7E8180, 24'd0);
        send_pix(12'd1920, 12'd5, 24'h000000, 24'd0);
        send_pix(12'd3, 12'd1080, 24'h000000, 24'd0);
        idle(2);
        check("tol_and_inactive_no_record", rpt_valid, 0);
        check("tol_and_inactive_count", error_count, 2);

        header(8'h07);
        rpt_ready = 1'b1;
        collect   = 1'b1;
        idle(1);
        for (int i = 0; i < 40; i++) begin
            send_pix(12'(100 + i), 12'd50, gen(12'(100 + i), 12'd50) ^ 24'h000010, 24'd0);
        end
        idle(4);
        collect   = 1'b0;
        rpt_ready = 1'b0;
        idle(1);
        check("cap_records", 64'(n_pop), 64'd16);
        check("cap_first", first_rec, 64'h10006400320000F0);
        check("cap_last", last_rec, 64'h10007300320000F0);
        check("cap_error_count", error_count, 16'd42);
        check("cap_no_overflow", overflow, 0);

        header(8'h08);
        for (int i = 0; i < 9; i++) begin
            send_pix(12'(200 + i), 12'd60, gen(12'(200 + i), 12'd60) ^ 24'h000010, 24'd0);
        end
        idle(2);
        check("ovf_valid", rpt_valid, 1);
        check("ovf_sticky", overflow, 1);
        check("ovf_error_count", error_count, 16'd51);
        for (int i = 0; i < 8; i++) begin
            want = {8'h10, 4'h0, 12'(200 + i), 4'h0, 12'd60, 24'h0000F0};
            check($sformatf("ovf_pop_%0d", i), rpt_data, want);
            pop_one();
        end
        check("ovf_drained", rpt_valid, 0);

        header(8'h09);
        send_pix(12'd300, 12'd70, gen(12'd300, 12'd70) ^ 24'h000010, 24'd0);
        idle(1);
        check("midq_valid", rpt_valid, 1);
        rst = 1'b1;
        #1;
        check("midq_rst_valid", rpt_valid, 0);
        check("midq_rst_locked", locked, 0);
        check("midq_rst_errors", error_count, 0);
        check("midq_rst_overflow", overflow, 0);
        idle(1);
        rst = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
